invert_and_threshold_soc_latency_profiler: RTL and testbench

AXI4 initiator that sequences reads of the SoC cycle counter (48-bit, 1-cycle read latency, 64-bit rdata with upper 16 bits zero) to time one run of the HLS kernel.
- On a kernel start pulse it reads a start timestamp; on the done pulse it reads an end timestamp.
- It computes the modular difference and pushes the latency into a small result FIFO, which firmware drains.
- It sits between the kernel control/status signals and the counter's AXI4 target read channel. Only the read channel is used; the counter's write channel is left to other initiators.

---
 rtl/invert_and_threshold_soc_latency_profiler_pkg.sv | 15 +
 rtl/invert_and_threshold_soc_latency_fifo.sv | 51 +++++
 rtl/invert_and_threshold_soc_latency_profiler.sv | 135 +++++++++++++
 tb/tb_invert_and_threshold_soc_latency_profiler.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/invert_and_threshold_soc_latency_profiler_pkg.sv
// invert_and_threshold_soc_latency_profiler_pkg: shared FSM states and AXI read constants
package invert_and_threshold_soc_latency_profiler_pkg;
   typedef enum logic [2:0] {
      IDLE,
      REQ_S,
      RESP_S,
      ARMED,
      REQ_E,
      RESP_E,
      PUSH
   } state_e;
   localparam logic [2:0] ARSIZE_8B  = 3'b011;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
endpackage

// File: rtl/invert_and_threshold_soc_latency_fifo.sv
// invert_and_threshold_soc_latency_fifo: small first-word-fall-through result FIFO
module invert_and_threshold_soc_latency_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 48
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push, do_pop;

   assign o_full  = count_q == (AW+1)'(DEPTH);
   assign o_empty = count_q == '0;
   assign do_push = i_push & ~o_full;
   assign do_pop  = i_pop & ~o_empty;
   assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

   // pointer/count update and storage write; full is judged before a same-cycle pop
   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wr_ptr_q] = i_data;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   // state registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         mem_q    <= '{default: '0};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end
endmodule

// File: rtl/invert_and_threshold_soc_latency_profiler.sv
// invert_and_threshold_soc_latency_profiler: times one kernel run by reading the SoC cycle counter over AXI4
module invert_and_threshold_soc_latency_profiler
   import invert_and_threshold_soc_latency_profiler_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 5,
   parameter int AXI_ADDR_WIDTH = 8,
   parameter int COUNT_WIDTH    = 48,
   parameter int FIFO_DEPTH     = 4,
   parameter int PROF_ID        = 0
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_start_pulse,
   input  logic                      i_done_pulse,
   output logic                      o_axi4init_arvalid,
   input  logic                      i_axi4init_arready,
   output logic [AXI_ADDR_WIDTH-1:0] o_axi4init_araddr,
   output logic [AXI_ID_WIDTH-1:0]   o_axi4init_arid,
   output logic [7:0]                o_axi4init_arlen,
   output logic [2:0]                o_axi4init_arsize,
   output logic [1:0]                o_axi4init_arburst,
   input  logic                      i_axi4init_rvalid,
   output logic                      o_axi4init_rready,
   input  logic [AXI_DATA_WIDTH-1:0] i_axi4init_rdata,
   input  logic [AXI_ID_WIDTH-1:0]   i_axi4init_rid,
   input  logic [1:0]                i_axi4init_rresp,
   input  logic                      i_axi4init_rlast,
   output logic                      o_res_valid,
   output logic [COUNT_WIDTH-1:0]    o_res_latency,
   input  logic                      i_res_ready,
   output logic                      o_busy,
   output logic                      o_overflow,
   output logic                      o_err
);
   state_e                 state_q, state_d;
   logic                   arvalid_q, arvalid_d, rready_q, rready_d;
   logic                   pending_q, pending_d, err_q, err_d, overflow_q, overflow_d;
   logic [COUNT_WIDTH-1:0] t_start_q, t_start_d, t_end_q, t_end_d, latency;
   logic                   push, fifo_full, fifo_empty, r_fire, r_ok, unused_ok;

   assign o_axi4init_araddr  = '0;
   assign o_axi4init_arid    = AXI_ID_WIDTH'(PROF_ID);
   assign o_axi4init_arlen   = 8'd0;
   assign o_axi4init_arsize  = ARSIZE_8B;
   assign o_axi4init_arburst = BURST_INCR;
   assign o_axi4init_arvalid = arvalid_q;
   assign o_axi4init_rready  = rready_q;
   assign o_busy             = state_q != IDLE;
   assign o_err              = err_q;
   assign o_overflow         = overflow_q;
   assign o_res_valid        = ~fifo_empty;
   assign r_fire             = i_axi4init_rvalid & rready_q;
   assign r_ok               = i_axi4init_rresp == RESP_OKAY;
   assign latency            = t_end_q - t_start_q;
   assign unused_ok          = ^{i_axi4init_rid, i_axi4init_rlast, i_axi4init_rdata};

   // sequencing FSM: two counter reads per run, then push of the modular difference
   always_comb begin
      state_d    = state_q;
      t_start_d  = t_start_q;
      t_end_d    = t_end_q;
      err_d      = err_q;
      overflow_d = overflow_q;
      pending_d  = pending_q;
      push       = 1'b0;
      case (state_q)
         IDLE:   state_d = i_start_pulse ? REQ_S : IDLE;
         REQ_S:  state_d = (arvalid_q & i_axi4init_arready) ? RESP_S : REQ_S;
         RESP_S: begin
            if (r_fire) begin
               err_d     = err_q | ~r_ok;
               t_start_d = r_ok ? i_axi4init_rdata[COUNT_WIDTH-1:0] : t_start_q;
               state_d   = !r_ok ? IDLE : (pending_q | i_done_pulse) ? REQ_E : ARMED;
            end
         end
         ARMED:  state_d = i_done_pulse ? REQ_E : ARMED;
         REQ_E:  state_d = (arvalid_q & i_axi4init_arready) ? RESP_E : REQ_E;
         RESP_E: begin
            if (r_fire) begin
               err_d   = err_q | ~r_ok;
               t_end_d = r_ok ? i_axi4init_rdata[COUNT_WIDTH-1:0] : t_end_q;
               state_d = r_ok ? PUSH : IDLE;
            end
         end
         PUSH: begin
            overflow_d = overflow_q | fifo_full;
            push       = ~fifo_full;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if ((state_q == REQ_S || state_q == RESP_S) && i_done_pulse) pending_d = 1'b1;
      if (state_q == RESP_S && state_d != RESP_S) pending_d = 1'b0;
      arvalid_d = state_d == REQ_S || state_d == REQ_E;
      rready_d  = state_d == RESP_S || state_d == RESP_E;
   end

   // state registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         pending_q  <= 1'b0;
         err_q      <= 1'b0;
         overflow_q <= 1'b0;
         t_start_q  <= '0;
         t_end_q    <= '0;
      end else begin
         state_q    <= state_d;
         arvalid_q  <= arvalid_d;
         rready_q   <= rready_d;
         pending_q  <= pending_d;
         err_q      <= err_d;
         overflow_q <= overflow_d;
         t_start_q  <= t_start_d;
         t_end_q    <= t_end_d;
      end
   end

   invert_and_threshold_soc_latency_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(COUNT_WIDTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (push),
      .i_data  (latency),
      .i_pop   (i_res_ready),
      .o_data  (o_res_latency),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );
endmodule

// File: tb/tb_invert_and_threshold_soc_latency_profiler.sv
// tb_invert_and_threshold_soc_latency_profiler: directed checks against a modelled AXI cycle counter
module tb_invert_and_threshold_soc_latency_profiler;
   logic        i_clk = 1'b0, i_reset = 1'b1;
   logic        i_start_pulse = 1'b0, i_done_pulse = 1'b0, i_res_ready = 1'b0;
   logic        arvalid, rready, rvalid = 1'b0;
   logic [7:0]  araddr, arlen;
   logic [4:0]  arid;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [63:0] rdata = '0;
   logic        res_valid, busy, overflow, err;
   logic [47:0] res_latency, cnt = '0, load_val = '0;
   logic        load_en = 1'b0, ar_block = 1'b0, bad = 1'b0;
   int          n_tests = 0, n_fail = 0;

   always #5 i_clk = ~i_clk;

   invert_and_threshold_soc_latency_profiler dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_start_pulse(i_start_pulse), .i_done_pulse(i_done_pulse),
      .o_axi4init_arvalid(arvalid), .i_axi4init_arready(!ar_block),
      .o_axi4init_araddr(araddr), .o_axi4init_arid(arid), .o_axi4init_arlen(arlen),
      .o_axi4init_arsize(arsize), .o_axi4init_arburst(arburst),
      .i_axi4init_rvalid(rvalid), .o_axi4init_rready(rready),
      .i_axi4init_rdata(rdata), .i_axi4init_rid(5'd0),
      .i_axi4init_rresp(bad ? 2'b10 : 2'b00), .i_axi4init_rlast(1'b1),
      .o_res_valid(res_valid), .o_res_latency(res_latency), .i_res_ready(i_res_ready),
      .o_busy(busy), .o_overflow(overflow), .o_err(err)
   );

   // free-running SoC counter with optional preload
   always @(posedge i_clk) cnt <= i_reset ? 48'd0 : load_en ? load_val : cnt + 48'd1;

   // counter target: one-cycle read latency, beat held until accepted
   always @(posedge i_clk) begin
      if (i_reset) rvalid <= 1'b0;
      else begin
         if (rvalid && rready) rvalid <= 1'b0;
         if (arvalid && !ar_block) begin
            rvalid <= 1'b1;
            rdata  <= {16'h0, cnt};
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && busy; i++) @(negedge i_clk);
      chk("idle_timeout", busy, 0);
   endtask

   task automatic measure(input int gap);
      i_start_pulse = 1'b1;
      @(negedge i_clk);
      i_start_pulse = 1'b0;
      repeat (gap - 1) @(negedge i_clk);
      i_done_pulse = 1'b1;
      @(negedge i_clk);
      i_done_pulse = 1'b0;
      wait_idle();
   endtask

   task automatic pop_chk(input string tag, input logic [47:0] exp);
      chk({tag, "_valid"}, res_valid, 1);
      chk({tag, "_lat"}, res_latency, exp);
      i_res_ready = 1'b1;
      @(negedge i_clk);
      i_res_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge i_clk);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_latency", res_latency, 0);
      chk("rst_flags", {overflow, err}, 0);
      chk("const_ar", {araddr, arid, arlen, arsize, arburst}, {8'd0, 5'd0, 8'd0, 3'b011, 2'b01});
      i_reset = 1'b0;
      repeat (10) @(negedge i_clk);
      // basic run of 100 cycles
      i_start_pulse = 1'b1;
      @(negedge i_clk);
      i_start_pulse = 1'b0;
      chk("t1_busy_mid", busy, 1);
      repeat (99) @(negedge i_clk);
      i_done_pulse = 1'b1;
      @(negedge i_clk);
      i_done_pulse = 1'b0;
      wait_idle();
      chk("t1_err", err, 0);
      pop_chk("t1", 48'd100);
      chk("t1_empty", res_valid, 0);
      // counter wraps during the run
      load_val = 48'hFFFF_FFFF_FFEC;
      load_en  = 1'b1;
      @(negedge i_clk);
      load_en  = 1'b0;
      measure(50);
      pop_chk("t2_wrap", 48'd50);
      // done arrives while start read is stalled by arready
      ar_block = 1'b1;
      i_start_pulse = 1'b1;
      @(negedge i_clk);
      i_start_pulse = 1'b0;
      i_done_pulse = 1'b1;
      @(negedge i_clk);
      i_done_pulse = 1'b0;
      repeat (3) @(negedge i_clk);
      ar_block = 1'b0;
      wait_idle();
      pop_chk("t3_pending", 48'd2);
      // five results with no draining: the fifth is dropped
      for (int k = 0; k < 5; k++) measure(10 + k);
      chk("t4_overflow", overflow, 1);
      for (int k = 0; k < 4; k++) pop_chk($sformatf("t4_pop%0d", k), 48'(10 + k));
      chk("t4_empty", res_valid, 0);
      // error response on the start read
      bad = 1'b1;
      i_start_pulse = 1'b1;
      @(negedge i_clk);
      i_start_pulse = 1'b0;
      for (int i = 0; i < 50 && !err; i++) @(negedge i_clk);
      chk("t5_err", err, 1);
      chk("t5_idle", busy, 0);
      chk("t5_no_result", res_valid, 0);
      bad = 1'b0;
      measure(30);
      chk("t5_recover_valid", res_valid, 1);
      chk("t5_recover_lat", res_latency, 48'd30);
      // reset while waiting on the end read
      i_start_pulse = 1'b1;
      @(negedge i_clk);
      i_start_pulse = 1'b0;
      repeat (19) @(negedge i_clk);
      i_done_pulse = 1'b1;
      @(negedge i_clk);
      i_done_pulse = 1'b0;
      for (int i = 0; i < 50 && !rready; i++) @(negedge i_clk);
      chk("t6_in_resp_e", rready, 1);
      i_reset = 1'b1;
      @(negedge i_clk);
      chk("t6_arvalid", arvalid, 0);
      chk("t6_rready", rready, 0);
      chk("t6_busy", busy, 0);
      chk("t6_fifo_empty", res_valid, 0);
      chk("t6_flags", {overflow, err}, 0);
      i_reset = 1'b0;
      @(negedge i_clk);
      measure(12);
      pop_chk("t6_after", 48'd12);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
